dtw_core_feeder: RTL
====================

# dtw_core_feeder

Sequencer that drives one `dtw_core_datapath` instance. It accepts a job (reference base address and length), resets the core, and streams `SQG_SIZE` query samples plus the reference words into the core. Reference words come from a synchronous-read reference memory. When the core signals done, it collects the minimum DTW score and position and returns them over a valid/ready result port. It sits between the host/DMA logic and the DTW core.

## Interface
- `width`, 16: sample/word/score width; matches the core.
- `SQG_SIZE`, 250: query length; matches the core.
- `AW`, 32: reference memory address width.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: job request; accepted only in IDLE.
- `ref_base` in AW: first reference address; latched on accept.
- `ref_len_i` in 32: reference length; latched on accept.
- `busy` out 1: high from accept until result handshake completes.
- `sq_valid` in 1, `sq_ready` out 1, `sq_data` in width: query sample stream.
- `ref_rd_en` out 1, `ref_addr` out AW: memory read request.
- `ref_rdata` in width: read data, valid exactly 1 cycle after `ref_rd_en`.
- `core_rst` out 1, `running` out 1: core reset and enable.
- `Input_squiggle` out width, `Rword` out width, `ref_len` out 32: core data.
- `minval` in width, `position` in 32, `done` in 1: core results.
- `res_valid` out 1, `res_ready` in 1, `res_minval` out width, `res_position` out 32: job result.

## Operation
- States:
  - IDLE → CLR on `start`.
  - CLR: `core_rst`=1 for 1 cycle → PRIME.
  - PRIME: `running`=1 for 1 cycle; core ignores the data in this cycle → FEED.
  - FEED → FLUSH when `done`=1 is sampled.
  - FLUSH: `running`=1 for 1 cycle so the core's Minval update commits → RESULT.
  - RESULT: `res_valid`=1 → IDLE on `res_ready`.
- If `ref_len_i`=0, go IDLE → RESULT directly with `res_minval`=all-ones and `res_position`=0. No samples are consumed and no reads are issued.
- FEED advance cycle: `running`=1 only when a reference word is available in the prefetch FIFO, and, while `sq_cnt`<SQG_SIZE, `sq_valid`=1. Otherwise `running`=0 and the core freezes.
- `sq_ready` = `running` & FEED & `sq_cnt`<SQG_SIZE. `Input_squiggle`=`sq_data` while `sq_cnt`<SQG_SIZE, else 0.
- `Rword` = FIFO head; the head is popped on each advance.
- Once `ref_cnt` reaches `ref_len`, the FIFO supplies the pad word PAD_WORD (all-ones) with no memory read.
- Reads: issue `ref_rd_en` with `ref_addr`=`ref_base`+`ref_cnt` whenever FIFO occupancy plus in-flight reads < 2 and `ref_cnt`<`ref_len`. Reads begin in CLR.
- `ref_len` output holds the latched value from accept until the next accept.
- `start` while `busy` is ignored.
- `sq_valid` outside FEED is not consumed.

## Timing
- Accept at cycle T; CLR at T+1; PRIME at T+2; the first sample can be consumed at T+3.
- With no stalls, FEED lasts `ref_len`+SQG_SIZE advance cycles (core pipeline depth SQG_SIZE).
- `res_minval`/`res_position` are registered on entry to RESULT and stable while `res_valid`=1.
- Reset values: `busy`=0, `sq_ready`=0, `ref_rd_en`=0, `ref_addr`=0, `core_rst`=1 while `rst`=1 then 0, `running`=0, `Input_squiggle`=0, `Rword`=0, `ref_len`=0, `res_valid`=0, `res_minval`=all-ones, `res_position`=0.
- `rst` mid-job: return to IDLE next cycle, flush the FIFO, and discard any in-flight read data.
- `done` arriving together with a stall: FLUSH still requires exactly one advance (`running`=1) cycle.
- A FIFO pop and push in the same cycle are allowed; occupancy stays the same.
- `sq_cnt` saturates at SQG_SIZE; `ref_cnt` is 32-bit and never wraps.

## Structure
- Shared package `dtw_pkg`: `width`/SQG_SIZE defaults, PAD_WORD, and state encoding (IDLE, CLR, PRIME, FEED, FLUSH, RESULT).
- Sub-module `dtw_ref_prefetch`: 2-entry FIFO with in-flight tracking and pad-word injection. The top level holds the FSM, counters and result registers.

## Test plan
- SQG_SIZE=4, `ref_len`=8, reference = 0..7, samples 2,3,4,5, no stalls → exactly 4 samples consumed, 8 reads at `ref_base`..+7, then 4 pad words. The result matches a golden model, e.g. `res_minval`=0 at the position of the best-aligned end.
- Same job with `sq_valid` toggling every other cycle → `running` low on every gap; the result is identical to the unstalled run.
- `ref_len_i`=0 → `res_valid` at T+1 with `res_minval`=16'hFFFF and `res_position`=0; `sq_ready` never asserted.
- `res_ready` held low for 10 cycles → `res_valid` and the result stay stable; `start` during this time is ignored; `busy`=1 throughout.
- `rst` asserted during FEED, followed by a new job → the second result is correct, with no stale FIFO data.
- `start` pulsed while `busy`=1 → no second job, no extra `core_rst`.

Source files
------------

// File: rtl/dtw_pkg.sv
// Shared constants and state encoding for the DTW core feeder.
package dtw_pkg;

  localparam int unsigned DTW_WIDTH    = 16;
  localparam int unsigned DTW_SQG_SIZE = 250;

  // Reference word fed once the real reference is exhausted.
  localparam logic [DTW_WIDTH-1:0] PAD_WORD = '1;

  typedef enum logic [2:0] {
    StIdle,
    StClr,
    StPrime,
    StFeed,
    StFlush,
    StResult
  } feeder_state_e;

endpackage

// File: rtl/dtw_ref_prefetch.sv
// Two-entry reference prefetch FIFO: tracks the single-cycle memory read in
// flight and substitutes PAD_WORD once every real reference word has drained.
module dtw_ref_prefetch
  import dtw_pkg::*;
#(
  parameter int unsigned width = DTW_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             active,
  input  logic             more_refs,
  input  logic             pop,
  input  logic [width-1:0] rdata,
  output logic             rd_en,
  output logic             avail,
  output logic [width-1:0] head
);

  logic [width-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             inflight_q;
  logic [1:0]       fill;
  logic             pad;
  logic             pop_fifo;

  // Read issue, pad detection and head selection.
  always_comb begin
    fill     = count_q + {1'b0, inflight_q};
    pad      = ~more_refs & ~inflight_q & (count_q == 2'd0);
    rd_en    = active & more_refs & (fill < 2'd2);
    avail    = active & ((count_q != 2'd0) | pad);
    pop_fifo = pop & (count_q != 2'd0);
    if (count_q != 2'd0) begin
      head = mem_q[rd_ptr_q];
    end else if (active & pad) begin
      head = PAD_WORD;
    end else begin
      head = '0;
    end
  end

  // FIFO storage; dropping inflight_q on reset/clear discards late read data.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_q    <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= rd_en;
      if (inflight_q) begin
        mem_q[wr_ptr_q] <= rdata;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_fifo) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, inflight_q} - {1'b0, pop_fifo};
    end
  end

endmodule

// File: rtl/dtw_core_feeder.sv
// Job sequencer for one DTW core: resets it, streams query samples and
// prefetched reference words, then returns the minimum score and position.
module dtw_core_feeder
  import dtw_pkg::*;
#(
  parameter int unsigned width    = DTW_WIDTH,
  parameter int unsigned SQG_SIZE = DTW_SQG_SIZE,
  parameter int unsigned AW       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AW-1:0]    ref_base,
  input  logic [31:0]      ref_len_i,
  output logic             busy,
  input  logic             sq_valid,
  output logic             sq_ready,
  input  logic [width-1:0] sq_data,
  output logic             ref_rd_en,
  output logic [AW-1:0]    ref_addr,
  input  logic [width-1:0] ref_rdata,
  output logic             core_rst,
  output logic             running,
  output logic [width-1:0] Input_squiggle,
  output logic [width-1:0] Rword,
  output logic [31:0]      ref_len,
  input  logic [width-1:0] minval,
  input  logic [31:0]      position,
  input  logic             done,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [width-1:0] res_minval,
  output logic [31:0]      res_position
);

  localparam int unsigned SqCntW = $clog2(SQG_SIZE + 1);

  feeder_state_e     state_q, state_d;
  logic [SqCntW-1:0] sq_cnt_q;
  logic [31:0]       ref_cnt_q;
  logic [AW-1:0]     ref_base_q;
  logic [31:0]       ref_len_q;
  logic [width-1:0]  res_minval_q;
  logic [31:0]       res_position_q;

  logic accept;
  logic advance;
  logic sq_full;
  logic fifo_active;
  logic fifo_avail;

  assign sq_full      = (sq_cnt_q == SqCntW'(SQG_SIZE));
  assign fifo_active  = (state_q == StClr) || (state_q == StPrime) ||
                        (state_q == StFeed) || (state_q == StFlush);
  assign busy         = (state_q != StIdle);
  assign res_valid    = (state_q == StResult);
  assign ref_len      = ref_len_q;
  assign ref_addr     = ref_base_q + AW'(ref_cnt_q);
  assign res_minval   = res_minval_q;
  assign res_position = res_position_q;

  dtw_ref_prefetch #(
    .width (width)
  ) u_prefetch (
    .clk       (clk),
    .rst       (rst),
    .clear     (state_q == StIdle),
    .active    (fifo_active),
    .more_refs (ref_cnt_q < ref_len_q),
    .pop       (advance),
    .rdata     (ref_rdata),
    .rd_en     (ref_rd_en),
    .avail     (fifo_avail),
    .head      (Rword)
  );

  // Next-state and core control.
  always_comb begin
    state_d        = state_q;
    accept         = 1'b0;
    advance        = 1'b0;
    running        = 1'b0;
    core_rst       = rst;
    sq_ready       = 1'b0;
    Input_squiggle = '0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          accept  = 1'b1;
          state_d = (ref_len_i == 32'd0) ? StResult : StClr;
        end
      end
      StClr: begin
        core_rst = 1'b1;
        state_d  = StPrime;
      end
      StPrime: begin
        running = 1'b1;
        state_d = StFeed;
      end
      StFeed: begin
        Input_squiggle = sq_full ? '0 : sq_data;
        // No advance once done is seen; FLUSH supplies the single commit cycle.
        if (done) begin
          state_d = StFlush;
        end else begin
          advance  = fifo_avail & (sq_full | sq_valid);
          running  = advance;
          sq_ready = advance & ~sq_full;
        end
      end
      StFlush: begin
        running = 1'b1;
        state_d = StResult;
      end
      StResult: begin
        if (res_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, job counters and result capture (core result sampled at end of FLUSH).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      sq_cnt_q       <= '0;
      ref_cnt_q      <= 32'd0;
      ref_base_q     <= '0;
      ref_len_q      <= 32'd0;
      res_minval_q   <= '1;
      res_position_q <= 32'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        ref_base_q <= ref_base;
        ref_len_q  <= ref_len_i;
        sq_cnt_q   <= '0;
        ref_cnt_q  <= 32'd0;
      end else begin
        if (sq_ready) begin
          sq_cnt_q <= sq_cnt_q + SqCntW'(1);
        end
        if (ref_rd_en) begin
          ref_cnt_q <= ref_cnt_q + 32'd1;
        end
      end
      if (accept && (ref_len_i == 32'd0)) begin
        res_minval_q   <= '1;
        res_position_q <= 32'd0;
      end else if (state_q == StFlush) begin
        res_minval_q   <= minval;
        res_position_q <= position;
      end
    end
  end

endmodule
